// File: rtl/ah_cpu2pl_s_axi_write_if.sv
// AXI4-Lite slave-side bundle for the CPU-to-PL write register block.
// master drives requests, slave drives readies and responses.
interface ah_cpu2pl_s_axi_write_if #(
    parameter int DW = 32,
    parameter int AW = 7
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/ah_cpu2pl_s_axi_write.sv
// AXI4-Lite bank of CPU-written output registers with per-register update pulses.
// Define AH_CPU2PL_WRITE_READBACK_EN to let reads return register contents.
module ah_cpu2pl_s_axi_write #(
    parameter int USED_OUTPUTS       = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESET,
    output logic [C_S_AXI_DATA_WIDTH*USED_OUTPUTS-1:0] output_write,
    output logic [USED_OUTPUTS-1:0]                    write_valid,
    ah_cpu2pl_s_axi_write_if.slave                     s_axi
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    typedef enum logic [1:0] {
        W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP
    } w_state_e;
    typedef enum logic {R_IDLE, R_VALID} r_state_e;

    w_state_e w_q, w_d;
    r_state_e r_q, r_d;

    logic [DW-1:0]           regs_q [USED_OUTPUTS];
    logic [4:0]              awidx_q;
    logic [DW-1:0]           wdata_q;
    logic [NB-1:0]           wstrb_q;
    logic [USED_OUTPUTS-1:0] wv_q;
    logic [1:0]              bresp_q;
    logic [DW-1:0]           rdata_q;
    logic [1:0]              rresp_q;

    logic          awready, wready, arready;
    logic          aw_hs, w_hs, ar_hs;
    logic          commit, c_ok, ar_ok;
    logic [4:0]    c_idx, ar_idx;
    logic [DW-1:0] c_data, rd_data;
    logic [NB-1:0] c_strb;

    function automatic logic idx_ok(input logic [4:0] idx);
        return {1'b0, idx} < 6'(USED_OUTPUTS);
    endfunction

    assign awready = !S_AXI_ARESET && (w_q == W_IDLE || w_q == W_HAVE_DATA);
    assign wready  = !S_AXI_ARESET && (w_q == W_IDLE || w_q == W_HAVE_ADDR);
    assign arready = !S_AXI_ARESET && (r_q == R_IDLE);
    assign aw_hs   = s_axi.S_AXI_AWVALID && awready;
    assign w_hs    = s_axi.S_AXI_WVALID && wready;
    assign ar_hs   = s_axi.S_AXI_ARVALID && arready;

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = (w_q == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = (r_q == R_VALID);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign write_valid         = wv_q;

    for (genvar g = 0; g < USED_OUTPUTS; g++) begin : g_out
        assign output_write[DW*g +: DW] = regs_q[g];
    end

    // Commit takes whichever half arrives live this cycle, the rest from latches.
    always_comb begin
        w_d    = w_q;
        commit = 1'b0;
        c_idx  = awidx_q;
        c_data = wdata_q;
        c_strb = wstrb_q;
        unique case (w_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    c_idx  = s_axi.S_AXI_AWADDR[6:2];
                    c_data = s_axi.S_AXI_WDATA;
                    c_strb = s_axi.S_AXI_WSTRB;
                    w_d    = W_RESP;
                end else if (aw_hs) begin
                    w_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit = 1'b1;
                    c_data = s_axi.S_AXI_WDATA;
                    c_strb = s_axi.S_AXI_WSTRB;
                    w_d    = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    c_idx  = s_axi.S_AXI_AWADDR[6:2];
                    w_d    = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) w_d = W_IDLE;
            end
            default: w_d = W_IDLE;
        endcase
    end

    assign c_ok = idx_ok(c_idx);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) w_q <= W_IDLE;
        else              w_q <= w_d;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= '0;
            wv_q    <= '0;
            for (int i = 0; i < USED_OUTPUTS; i++) regs_q[i] <= '0;
        end else begin
            wv_q <= '0;
            if (w_q == W_IDLE && aw_hs) awidx_q <= s_axi.S_AXI_AWADDR[6:2];
            if (w_q == W_IDLE && w_hs) begin
                wdata_q <= s_axi.S_AXI_WDATA;
                wstrb_q <= s_axi.S_AXI_WSTRB;
            end
            if (commit) begin
                bresp_q <= c_ok ? 2'b00 : 2'b10;
                for (int i = 0; i < USED_OUTPUTS; i++) begin
                    if (c_ok && c_idx == 5'(i)) begin
                        wv_q[i] <= 1'b1;
                        for (int b = 0; b < NB; b++)
                            if (c_strb[b]) regs_q[i][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ar_idx = s_axi.S_AXI_ARADDR[6:2];
    assign ar_ok  = idx_ok(ar_idx);

    always_comb begin
        rd_data = '0;
`ifdef AH_CPU2PL_WRITE_READBACK_EN
        for (int i = 0; i < USED_OUTPUTS; i++)
            if (ar_idx == 5'(i)) rd_data = regs_q[i];
`endif
    end

    always_comb begin
        r_d = r_q;
        unique case (r_q)
            R_IDLE:  if (ar_hs) r_d = R_VALID;
            R_VALID: if (s_axi.S_AXI_RREADY) r_d = R_IDLE;
            default: r_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_q     <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            r_q <= r_d;
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= ar_ok ? 2'b00 : 2'b10;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};
endmodule

// File: tb/tb_ah_cpu2pl_s_axi_write.sv
// Directed bench for ah_cpu2pl_s_axi_write (USED_OUTPUTS=4) against a
// transaction-level register model checked every cycle.
module tb_ah_cpu2pl_s_axi_write;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [32*N-1:0] output_write;
    logic [N-1:0]    write_valid;

    ah_cpu2pl_s_axi_write_if #(.DW(32), .AW(7)) bus ();

    ah_cpu2pl_s_axi_write #(
        .USED_OUTPUTS(N),
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(7)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .output_write(output_write),
        .write_valid(write_valid),
        .s_axi(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [31:0] exp_regs [N];
    logic [N-1:0] exp_wv = '0;
    bit          commit_pend = 0;
    logic [6:0]  commit_addr;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;

    logic [N-1:0] cap_wv;
    logic [1:0]   cap_bresp;
    logic [31:0]  cap_rdata;
    logic [1:0]   cap_rresp;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [32*N-1:0] exp_packed();
        logic [32*N-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = exp_regs[i];
        return v;
    endfunction

    function automatic bit in_range(input logic [6:0] a);
        return int'(a[6:2]) < N;
    endfunction

    // A register's new value and its pulse appear together after the commit edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) exp_regs[i] = '0;
            exp_wv = '0;
            commit_pend = 0;
        end else begin
            exp_wv = '0;
            if (commit_pend) begin
                commit_pend = 0;
                if (in_range(commit_addr)) begin
                    int k;
                    k = int'(commit_addr[6:2]);
                    exp_wv[k] = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (commit_strb[b])
                            exp_regs[k][8*b +: 8] = commit_data[8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("output_write", output_write, exp_packed());
            chk("write_valid", write_valid, exp_wv);
        end
    end

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly,
                             input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, fa, fw;
        int cyc = 0;
        logic [1:0] eb;
        eb = in_range(addr) ? 2'b00 : 2'b10;
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        bus.S_AXI_BREADY = 1'b0;
        while (!(aw_done && w_done)) begin
            bus.S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            bus.S_AXI_WVALID  = !w_done && cyc >= w_dly;
            @(negedge clk);
            fa = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            fw = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            if ((fa || aw_done) && (fw || w_done)) begin
                commit_pend = 1;
                commit_addr = addr;
                commit_data = data;
                commit_strb = strb;
            end
            aw_done |= fa;
            w_done  |= fw;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 30) begin
                chk("write_timeout", 1, 0);
                break;
            end
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        chk("bvalid_set", bus.S_AXI_BVALID, 1);
        chk("bresp", bus.S_AXI_BRESP, eb);
        chk("awready_in_resp", bus.S_AXI_AWREADY, 0);
        cap_wv    = write_valid;
        cap_bresp = bus.S_AXI_BRESP;
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bvalid_hold", bus.S_AXI_BVALID, 1);
            chk("bresp_hold", bus.S_AXI_BRESP, eb);
        end
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk("bvalid_clear", bus.S_AXI_BVALID, 0);
        chk("awready_back", bus.S_AXI_AWREADY, 1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [6:0] addr, input int hold);
        logic [31:0] ed;
        logic [1:0]  er;
        int cyc = 0;
        bit fired = 0;
        er = in_range(addr) ? 2'b00 : 2'b10;
        ed = '0;
`ifdef AH_CPU2PL_WRITE_READBACK_EN
        if (in_range(addr)) ed = exp_regs[int'(addr[6:2])];
`endif
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        while (!fired) begin
            @(negedge clk);
            fired = bus.S_AXI_ARREADY;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 30) begin
                chk("read_timeout", 1, 0);
                break;
            end
        end
        bus.S_AXI_ARVALID = 1'b0;
        for (int k = 0; k < (hold < 1 ? 1 : hold); k++) begin
            @(negedge clk);
            chk("rvalid_hold", bus.S_AXI_RVALID, 1);
            chk("arready_busy", bus.S_AXI_ARREADY, 0);
            chk("rdata", bus.S_AXI_RDATA, ed);
            chk("rresp", bus.S_AXI_RRESP, er);
            cap_rdata = bus.S_AXI_RDATA;
            cap_rresp = bus.S_AXI_RRESP;
            @(posedge clk); #1;
        end
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0;
        @(negedge clk);
        chk("rvalid_clear", bus.S_AXI_RVALID, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 0;
        bus.S_AXI_BREADY = 0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 0;
        bus.S_AXI_RREADY = 0;

        @(posedge clk); #1;
        started = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", bus.S_AXI_AWREADY, 0);
        chk("rst_arready", bus.S_AXI_ARREADY, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("r18_awready", bus.S_AXI_AWREADY, 1);
        chk("r18_wready", bus.S_AXI_WREADY, 1);
        chk("r18_arready", bus.S_AXI_ARREADY, 1);
        chk("r18_bvalid", bus.S_AXI_BVALID, 0);
        chk("r18_rvalid", bus.S_AXI_RVALID, 0);
        chk("r18_out", output_write, 0);
        chk("r18_wv", write_valid, 0);
        @(posedge clk); #1;

        axi_write(7'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("r19_wv", cap_wv, 4'b0100);
        chk("r19_bresp", cap_bresp, 2'b00);
        chk("r19_reg2", output_write[95:64], 32'hDEADBEEF);

        axi_write(7'h04, 32'h12345678, 4'hF, 0, 0, 2);
        axi_write(7'h04, 32'h000000AA, 4'h1, 3, 0, 0);
        chk("r20_wv", cap_wv, 4'b0010);
        chk("r20_bresp", cap_bresp, 2'b00);
        chk("r20_reg1", output_write[63:32], 32'h123456AA);

        axi_write(7'h00, 32'hA5A50000, 4'hC, 0, 2, 1);
        chk("aw_first_reg0", output_write[31:0], 32'hA5A50000);

        axi_write(7'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        chk("strb0_wv", cap_wv, 4'b1000);
        chk("strb0_reg3", output_write[127:96], 32'h0);

        axi_write(7'h40, 32'h55555555, 4'hF, 1, 0, 1);
        chk("r21_bresp", cap_bresp, 2'b10);
        chk("r21_wv", cap_wv, 4'b0000);
        chk("r21_reg2", output_write[95:64], 32'hDEADBEEF);

        axi_read(7'h08, 5);
`ifdef AH_CPU2PL_WRITE_READBACK_EN
        chk("r22_rdata", cap_rdata, 32'hDEADBEEF);
`else
        chk("r22_rdata", cap_rdata, 32'h0);
`endif
        axi_read(7'h04, 1);
        axi_read(7'h7C, 2);
        chk("oor_rresp", cap_rresp, 2'b10);
        chk("oor_rdata", cap_rdata, 32'h0);

        bus.S_AXI_AWADDR  = 7'h08;
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        chk("r23_aw_hs", bus.S_AXI_AWREADY, 1);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        chk("r23_have_addr", bus.S_AXI_WREADY, 1);
        chk("r23_have_addr_aw", bus.S_AXI_AWREADY, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.S_AXI_WDATA  = 32'h11111111;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("r23_bvalid_rst", bus.S_AXI_BVALID, 0);
            @(posedge clk); #1;
        end
        bus.S_AXI_WVALID = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("r23_awready", bus.S_AXI_AWREADY, 1);
        chk("r23_wready", bus.S_AXI_WREADY, 1);
        chk("r23_arready", bus.S_AXI_ARREADY, 1);
        chk("r23_regs", output_write, 0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("r23_bvalid_after", bus.S_AXI_BVALID, 0);
            chk("r23_wv_after", write_valid, 0);
        end
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
